// File: rtl/h80bus_initiator.sv
// h80 I/O bus initiator: turns one valid/ready request into a single bus
// read or write cycle (setup, strobe with responder wait states, hold),
// then reports completion on a one-cycle rsp_valid pulse.
module h80bus_initiator #(
  parameter int DATA_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 16,
  parameter int SETUP_CYCLES = 1,
  parameter int HOLD_CYCLES  = 1,
  parameter int MAX_WAIT     = 255
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic                  ce_n,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  rd_n,
  output logic                  wr_n,
  inout  wire  [DATA_WIDTH-1:0] data,
  input  logic                  buswait_n
);

  // One shared counter serves setup, wait and hold phases, so it must hold the largest.
  localparam int CNT_MAX_SH = (SETUP_CYCLES > HOLD_CYCLES) ? SETUP_CYCLES : HOLD_CYCLES;
  localparam int CNT_MAX    = (CNT_MAX_SH > MAX_WAIT) ? CNT_MAX_SH : MAX_WAIT;
  localparam int CW         = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] C_SETUP_LAST = CW'(SETUP_CYCLES - 1);
  localparam logic [CW-1:0] C_HOLD_LAST  = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] C_WAIT_MAX   = CW'(MAX_WAIT);
  localparam logic [CW-1:0] C_SAT        = CW'(CNT_MAX);

  generate
    if (SETUP_CYCLES < 1) begin : g_bad_setup
      $error("h80bus_initiator: SETUP_CYCLES must be >= 1");
    end
    if (HOLD_CYCLES < 1) begin : g_bad_hold
      $error("h80bus_initiator: HOLD_CYCLES must be >= 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_state_next;
  logic [CW-1:0]         r_cnt;
  logic                  r_we;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_cap_rdata;
  logic                  r_cap_timeout;
  logic [DATA_WIDTH-1:0] r_rsp_rdata;
  logic                  r_rsp_timeout;
  logic                  w_drive;
  logic                  w_timeout_hit;

  // In STROBE the counter holds the number of wait cycles already spent.
  assign w_timeout_hit = (MAX_WAIT != 0) && (r_cnt == C_WAIT_MAX);

  // State register; reset drops any cycle in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_next;
  end

  // Next-state decode and bus/handshake outputs, all decoded from the state register.
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    ce_n         = 1'b1;
    rd_n         = 1'b1;
    wr_n         = 1'b1;
    w_drive      = 1'b0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) w_state_next = S_SETUP;
      end
      S_SETUP: begin
        ce_n    = 1'b0;
        w_drive = r_we;
        if (r_cnt == C_SETUP_LAST) w_state_next = S_STROBE;
      end
      S_STROBE: begin
        ce_n    = 1'b0;
        rd_n    = r_we;
        wr_n    = ~r_we;
        w_drive = r_we;
        if (buswait_n || w_timeout_hit) w_state_next = S_HOLD;
      end
      S_HOLD: begin
        ce_n    = 1'b0;
        w_drive = r_we;
        if (r_cnt == C_HOLD_LAST) w_state_next = S_RESP;
      end
      S_RESP: begin
        rsp_valid    = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Phase counter: cleared on every state change, saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                  r_cnt <= '0;
    else if (r_state != w_state_next) r_cnt <= '0;
    else if (r_cnt != C_SAT)       r_cnt <= r_cnt + CW'(1);
  end

  // Latch the request on the accept edge; bus address and write data come from here.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (r_state == S_IDLE && req_valid) begin
      r_we    <= req_we;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  // Capture the strobe outcome; writes keep the previous read data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cap_rdata   <= '0;
      r_cap_timeout <= 1'b0;
    end else if (r_state == S_STROBE) begin
      if (buswait_n) begin
        r_cap_rdata   <= r_we ? r_rsp_rdata : data;
        r_cap_timeout <= 1'b0;
      end else if (w_timeout_hit) begin
        r_cap_rdata   <= '1;
        r_cap_timeout <= 1'b1;
      end
    end
  end

  // Publish the result as the cycle completes so it stays stable until the next completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_rdata   <= '0;
      r_rsp_timeout <= 1'b0;
    end else if (r_state == S_HOLD && w_state_next == S_RESP) begin
      r_rsp_rdata   <= r_cap_rdata;
      r_rsp_timeout <= r_cap_timeout;
    end
  end

  assign addr        = r_addr;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_timeout = r_rsp_timeout;
  assign data        = w_drive ? r_wdata : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_h80bus_initiator.sv
// Directed bench for h80bus_initiator with a small wait-state responder.
module tb_h80bus_initiator;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [15:0] req_addr;
  logic [7:0]  req_wdata;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_timeout;
  logic        ce_n;
  logic [15:0] addr;
  logic        rd_n;
  logic        wr_n;
  wire  [7:0]  data;
  logic        buswait_n;

  // Responder: drives tb_rval on reads when enabled; tb_probe drives it unconditionally
  // so any simultaneous drive from the initiator corrupts the observed value.
  logic        tb_rd_en;
  logic        tb_probe;
  logic [7:0]  tb_rval;
  int          tb_waits;
  logic        tb_stuck;
  int          strobe_cnt = 0;

  assign data      = ((!rd_n && tb_rd_en) || tb_probe) ? tb_rval : 8'hzz;
  assign buswait_n = tb_stuck ? 1'b0 : (strobe_cnt >= tb_waits);

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rd_n || !wr_n) strobe_cnt <= strobe_cnt + 1;
    else                strobe_cnt <= 0;
  end

  h80bus_initiator #(
    .DATA_WIDTH(8), .ADDR_WIDTH(16), .SETUP_CYCLES(1), .HOLD_CYCLES(1), .MAX_WAIT(4)
  ) dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .ce_n(ce_n), .addr(addr), .rd_n(rd_n), .wr_n(wr_n), .data(data), .buswait_n(buswait_n)
  );

  int          tests_run = 0;
  int          fails = 0;
  int          cyc = 0;
  int          wr_low, rd_low, both_low, rd_bad, rsp_cnt, rsp_cyc, ce_run, last_gap;
  logic [7:0]  wr_data_seen, rsp_rd;
  logic        wr_ce_seen, rsp_to;
  logic [15:0] addr_seen;

  task automatic clear_stats();
    wr_low = 0; rd_low = 0; both_low = 0; rd_bad = 0; rsp_cnt = 0; rsp_cyc = -1;
    ce_run = 0; last_gap = -1; wr_data_seen = 8'h00; wr_ce_seen = 1'b1;
    rsp_rd = 8'h00; rsp_to = 1'b0; addr_seen = 16'h0000;
  endtask

  // Advance to the next falling edge and sample the bus there.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (!wr_n) begin wr_low++; wr_data_seen = data; wr_ce_seen = ce_n; addr_seen = addr; end
    if (!rd_n) begin rd_low++; addr_seen = addr; end
    if (!rd_n && !wr_n) both_low++;
    if (!rd_n && tb_rd_en && data !== tb_rval) rd_bad++;
    if (rsp_valid) begin rsp_cnt++; rsp_cyc = cyc; rsp_rd = rsp_rdata; rsp_to = rsp_timeout; end
    if (ce_n) ce_run++;
    else begin
      if (ce_run > 0) last_gap = ce_run;
      ce_run = 0;
    end
  endtask

  // Present one request; acc is the cycle number of the accept edge's negedge before it.
  task automatic issue(input logic we, input logic [15:0] a, input logic [7:0] d, output int acc);
    int n = 0;
    while (!req_ready && n < 20) begin step(); n++; end
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    acc = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_cnt < target && n < 40) begin step(); n++; end
    tests_run++;
    if (rsp_cnt < target) begin fails++; $display("FAIL rsp_wait: got %0d pulses, expected %0d", rsp_cnt, target); end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    repeat (3) step();
    tests_run++; if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b expected 1", req_ready); end
    tests_run++; if ({ce_n, rd_n, wr_n} !== 3'b111) begin fails++; $display("FAIL reset_strobes: got %b expected 111", {ce_n, rd_n, wr_n}); end
    tests_run++; if (addr !== 16'h0000) begin fails++; $display("FAIL reset_addr: got %h expected 0000", addr); end
    tests_run++; if ({rsp_valid, rsp_timeout, rsp_rdata} !== 10'h000) begin fails++; $display("FAIL reset_rsp: got %b/%b/%h expected 0/0/00", rsp_valid, rsp_timeout, rsp_rdata); end
    reset_n = 1'b1;
    step();
    $display("[TB] reset: ready=%b ce_n=%b", req_ready, ce_n);
  endtask

  task automatic test_write();
    int acc;
    clear_stats(); tb_waits = 0; tb_rd_en = 1'b0;
    issue(1'b1, 16'h0000, 8'h41, acc);
    wait_rsp(1);
    tests_run++; if (wr_low != 1) begin fails++; $display("FAIL write_wr_low: got %0d expected 1", wr_low); end
    tests_run++; if (wr_data_seen !== 8'h41 || wr_ce_seen !== 1'b0) begin fails++; $display("FAIL write_data: got %h ce_n=%b expected 41 ce_n=0", wr_data_seen, wr_ce_seen); end
    tests_run++; if (rsp_cyc - acc != 4) begin fails++; $display("FAIL write_latency: got %0d expected 4", rsp_cyc - acc); end
    tests_run++; if (rsp_to !== 1'b0) begin fails++; $display("FAIL write_timeout: got %b expected 0", rsp_to); end
    $display("[TB] write addr=0000 data=%h ('%c') latency=%0d", wr_data_seen, wr_data_seen, rsp_cyc - acc);
  endtask

  task automatic test_read_wait();
    int acc;
    clear_stats(); tb_waits = 3; tb_rd_en = 1'b1; tb_rval = 8'h5A;
    issue(1'b0, 16'h1234, 8'h3C, acc);
    wait_rsp(1);
    tests_run++; if (rd_low != 4) begin fails++; $display("FAIL read_rd_low: got %0d expected 4", rd_low); end
    tests_run++; if (rsp_rd !== 8'h5A) begin fails++; $display("FAIL read_rdata: got %h expected 5a", rsp_rd); end
    tests_run++; if (rsp_cyc - acc != 7) begin fails++; $display("FAIL read_latency: got %0d expected 7", rsp_cyc - acc); end
    tests_run++; if (addr_seen !== 16'h1234) begin fails++; $display("FAIL read_addr: got %h expected 1234", addr_seen); end
    tests_run++; if (rd_bad != 0 || rsp_to !== 1'b0) begin fails++; $display("FAIL read_bus: got contention=%0d timeout=%b expected 0/0", rd_bad, rsp_to); end
    $display("[TB] read addr=1234 rdata=%h waits=3 latency=%0d", rsp_rd, rsp_cyc - acc);
  endtask

  task automatic test_timeout();
    int acc;
    clear_stats(); tb_stuck = 1'b1; tb_rd_en = 1'b1; tb_rval = 8'h12;
    issue(1'b0, 16'h0042, 8'h00, acc);
    wait_rsp(1);
    tb_stuck = 1'b0;
    step();
    tests_run++; if (rsp_to !== 1'b1 || rsp_rd !== 8'hFF) begin fails++; $display("FAIL timeout_rsp: got to=%b rdata=%h expected 1/ff", rsp_to, rsp_rd); end
    tests_run++; if (rd_low != 5) begin fails++; $display("FAIL timeout_rd_low: got %0d expected 5", rd_low); end
    tests_run++; if (rsp_cyc - acc != 8) begin fails++; $display("FAIL timeout_latency: got %0d expected 8", rsp_cyc - acc); end
    tests_run++; if ({ce_n, rd_n, req_ready} !== 3'b111) begin fails++; $display("FAIL timeout_idle: got %b expected 111", {ce_n, rd_n, req_ready}); end
    $display("[TB] timeout read addr=0042 to=%b rdata=%h latency=%0d", rsp_to, rsp_rd, rsp_cyc - acc);
  endtask

  task automatic test_back_to_back();
    int acc, r1;
    logic [7:0] first_data;
    clear_stats(); tb_waits = 0; tb_rd_en = 1'b0;
    req_we = 1'b1; req_addr = 16'h0010; req_wdata = 8'h11; req_valid = 1'b1;
    acc = cyc; r1 = -1; first_data = 8'h00;
    for (int n = 0; n < 40 && rsp_cnt < 2; n++) begin
      step();
      if (rsp_cnt == 1 && r1 < 0) begin
        r1 = rsp_cyc; first_data = wr_data_seen; req_addr = 16'h0011; req_wdata = 8'h22;
      end
      if (r1 >= 0 && cyc == r1 + 2) req_valid = 1'b0;
    end
    req_valid = 1'b0;
    repeat (6) step();
    tests_run++; if (rsp_cnt != 2) begin fails++; $display("FAIL b2b_count: got %0d expected 2", rsp_cnt); end
    tests_run++; if (r1 - acc != 4) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 4", r1 - acc); end
    tests_run++; if (rsp_cyc - r1 != 5) begin fails++; $display("FAIL b2b_spacing: got %0d expected 5", rsp_cyc - r1); end
    tests_run++; if (last_gap != 2) begin fails++; $display("FAIL b2b_idle_gap: got %0d expected 2", last_gap); end
    tests_run++; if (first_data !== 8'h11 || wr_data_seen !== 8'h22) begin fails++; $display("FAIL b2b_data: got %h,%h expected 11,22", first_data, wr_data_seen); end
    tests_run++; if (rsp_rd !== 8'hFF || rsp_to !== 1'b0) begin fails++; $display("FAIL b2b_rsp_hold: got rdata=%h to=%b expected ff/0", rsp_rd, rsp_to); end
    $display("[TB] back-to-back writes 11,22 gap=%0d spacing=%0d", last_gap, rsp_cyc - r1);
  endtask

  task automatic test_reset_mid();
    int acc, n;
    clear_stats(); tb_waits = 3; tb_rd_en = 1'b0;
    issue(1'b1, 16'h0055, 8'h41, acc);
    n = 0;
    while (wr_n && n < 10) begin step(); n++; end
    #2;
    tb_rval = 8'h00; tb_probe = 1'b1;
    reset_n = 1'b0;
    #1;
    tests_run++; if ({ce_n, wr_n} !== 2'b11) begin fails++; $display("FAIL midreset_strobes: got %b expected 11", {ce_n, wr_n}); end
    tests_run++; if (data !== 8'h00) begin fails++; $display("FAIL midreset_data_release: got %h expected 00", data); end
    tb_probe = 1'b0;
    repeat (2) step();
    reset_n = 1'b1;
    repeat (8) step();
    tests_run++; if (rsp_cnt != 0) begin fails++; $display("FAIL midreset_no_rsp: got %0d expected 0", rsp_cnt); end
    tests_run++; if (rsp_rdata !== 8'h00) begin fails++; $display("FAIL midreset_rdata_clr: got %h expected 00", rsp_rdata); end
    clear_stats(); tb_waits = 0; tb_rd_en = 1'b1; tb_rval = 8'hA5;
    issue(1'b0, 16'h0077, 8'hFF, acc);
    wait_rsp(1);
    tests_run++; if (rsp_rd !== 8'hA5 || rsp_cyc - acc != 4) begin fails++; $display("FAIL midreset_read: got %h lat=%0d expected a5 lat=4", rsp_rd, rsp_cyc - acc); end
    $display("[TB] reset mid-write, then read addr=0077 rdata=%h", rsp_rd);
  endtask

  task automatic test_read_no_drive();
    int acc;
    clear_stats(); tb_rd_en = 1'b1;
    tb_waits = 2; tb_rval = 8'h00;
    issue(1'b0, 16'h0100, 8'hFF, acc);
    wait_rsp(1);
    tests_run++; if (rsp_rd !== 8'h00) begin fails++; $display("FAIL nodrive_rdata0: got %h expected 00", rsp_rd); end
    tb_waits = 0; tb_rval = 8'hC3;
    issue(1'b0, 16'h0101, 8'hFF, acc);
    wait_rsp(2);
    tests_run++; if (rsp_rd !== 8'hC3) begin fails++; $display("FAIL nodrive_rdata1: got %h expected c3", rsp_rd); end
    tests_run++; if (rd_bad != 0 || both_low != 0) begin fails++; $display("FAIL nodrive_bus: got contention=%0d both_low=%0d expected 0/0", rd_bad, both_low); end
    tests_run++; if (rd_low != 4) begin fails++; $display("FAIL nodrive_rd_low: got %0d expected 4", rd_low); end
    $display("[TB] reads without initiator drive: contention=%0d", rd_bad);
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_addr = 16'h0000; req_wdata = 8'h00;
    tb_rd_en = 1'b0; tb_probe = 1'b0; tb_rval = 8'h00; tb_waits = 0; tb_stuck = 1'b0;
    clear_stats();
    test_reset();
    test_write();
    test_read_wait();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_read_no_drive();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
